// File: rtl/pipe_adder_n.sv
// pipe_adder_n: WIDTH-bit add/subtract with the carry chain split into
// WIDTH/LANE registered stages. Elastic valid/ready handshake with a single
// global advance enable: the whole pipe moves or the whole pipe holds.

// One LANE-bit slice of the carry chain.
module pipe_adder_lane #(
  parameter int LANE = 4
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic            ci,
  output logic [LANE-1:0] s,
  output logic            co
);
  logic [LANE:0] sum;

  // Widen explicitly so the carry out lands in the top bit.
  assign sum = {1'b0, a} + {1'b0, b} + {{LANE{1'b0}}, ci};
  assign s   = sum[LANE-1:0];
  assign co  = sum[LANE];
endmodule

module pipe_adder_n #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / LANE;

  // Stage registers. Stage k holds the operands, the result slices finished
  // so far (slices 0..k) and the carry out of slice k.
  logic [STAGES-1:0]            vld_pipe;
  logic [STAGES-1:0]            c_pipe;
  logic [STAGES-1:0][WIDTH-1:0] a_pipe;
  logic [STAGES-1:0][WIDTH-1:0] b_pipe;
  logic [STAGES-1:0][WIDTH-1:0] s_pipe;
  logic                         ovf_q;

  // Stage inputs: stage 0 sees the port, stage k sees stage k-1.
  logic [STAGES-1:0]            v_src;
  logic [STAGES-1:0]            c_src;
  logic [STAGES-1:0][WIDTH-1:0] a_src;
  logic [STAGES-1:0][WIDTH-1:0] b_src;
  logic [STAGES-1:0][WIDTH-1:0] s_src;

  logic [STAGES-1:0][LANE-1:0]  sl;
  logic [STAGES-1:0]            co;
  logic                         en;
  logic                         ovf_nxt;

  // Pipe advances unless a finished result is waiting on the consumer.
  assign en       = !vld_pipe[STAGES-1] || out_ready;
  assign in_ready = en;

  // Route each stage's source. Subtract folds into an add of ~B with ~borrow.
  always_comb begin
    v_src    = '0;
    c_src    = '0;
    a_src    = '0;
    b_src    = '0;
    s_src    = '0;
    v_src[0] = in_valid;
    a_src[0] = inA;
    b_src[0] = sub ? ~inB : inB;
    c_src[0] = sub ? ~cin : cin;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = vld_pipe[k-1];
      c_src[k] = c_pipe[k-1];
      a_src[k] = a_pipe[k-1];
      b_src[k] = b_pipe[k-1];
      s_src[k] = s_pipe[k-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_lane
      pipe_adder_lane #(.LANE(LANE)) u_lane (
        .a  (a_src[g][g*LANE +: LANE]),
        .b  (b_src[g][g*LANE +: LANE]),
        .ci (c_src[g]),
        .s  (sl[g]),
        .co (co[g])
      );
    end
  endgenerate

  // Signed overflow from the effective operand MSBs and the final result MSB.
  always_comb begin
    ovf_nxt = (a_src[STAGES-1][WIDTH-1] == b_src[STAGES-1][WIDTH-1]) &&
              (sl[STAGES-1][LANE-1] != a_src[STAGES-1][WIDTH-1]);
  end

  // Shift every stage together on en; bubbles ride along as valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      c_pipe   <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
      s_pipe   <= '0;
      ovf_q    <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_pipe[k]                  <= v_src[k];
        c_pipe[k]                    <= co[k];
        a_pipe[k]                    <= a_src[k];
        b_pipe[k]                    <= b_src[k];
        s_pipe[k]                    <= s_src[k];
        s_pipe[k][k*LANE +: LANE]    <= sl[k];
      end
      ovf_q <= ovf_nxt;
    end
  end

  // Operands in the last stage have no consumer.
  logic unused_ok;
  assign unused_ok = &{1'b0, a_pipe[STAGES-1], b_pipe[STAGES-1]};

  assign out_valid = vld_pipe[STAGES-1];
  assign s         = s_pipe[STAGES-1];
  assign cout      = c_pipe[STAGES-1];
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_adder_n.sv
// Directed bench for pipe_adder_n at WIDTH=16, LANE=4.
module tb_pipe_adder_n;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] inA, inB;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [15:0] s;
  logic        cout, ovf;

  int total = 0;
  int bad   = 0;

  logic [33:0] in_q[$];   // {sub, cin, B, A}
  logic [17:0] exp_q[$];  // {ovf, cout, s}

  pipe_adder_n #(.WIDTH(16), .LANE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: s = A + B + cin, or A - B - cin; ovf on signed wrap.
  function automatic logic [17:0] model(input logic [33:0] bt);
    logic [15:0] a, b;
    logic        ci, sb, o;
    logic [16:0] t;
    a  = bt[15:0];
    b  = bt[31:16];
    ci = bt[32];
    sb = bt[33];
    if (!sb) begin
      t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      o = (a[15] == b[15]) && (t[15] != a[15]);
    end else begin
      t = {1'b0, a} + {1'b0, ~b} + {16'd0, ~ci};
      o = (a[15] != b[15]) && (t[15] != a[15]);
    end
    return {o, t[16], t[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipe; check latency, result and no duplicate.
  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb,
                          input logic [15:0] es, input logic ec, input logic eo);
    int n;
    inA = a; inB = b; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    inA = 16'h5A5A; inB = 16'hA5A5; cin = ~ci; sub = ~sb;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick();
    chk({tag, "_dup"}, out_valid, 0);
  endtask

  // Stream in_q through the DUT with out_ready low for cycles [lo, hi).
  task automatic run_stream(input string tag, input int lo, input int hi, input int max_cyc);
    int          c;
    logic        held_v;
    logic [17:0] held;
    logic [33:0] bt;
    c = 0; held_v = 1'b0; held = '0; bt = '0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && c < max_cyc) begin
      out_ready = !(c >= lo && c < hi);
      if (in_q.size() > 0) begin
        bt = in_q[0];
        {sub, cin, inB, inA} = bt;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        chk({tag, "_hold_v"}, out_valid, 1);
        chk({tag, "_hold_d"}, {ovf, cout, s}, held);
      end
      if (out_valid && !out_ready) begin
        chk({tag, "_stall_rdy"}, in_ready, 0);
        held_v = 1'b1;
        held   = {ovf, cout, s};
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk({tag, "_extra"}, out_valid, 0);
        else chk({tag, "_res"}, {ovf, cout, s}, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bt));
        void'(in_q.pop_front());
      end
      tick();
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_left"}, in_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] r;
    int          seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inA = '0; inB = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_irdy", in_ready, 1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    send_one("carry12", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send_one("wrap",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("povf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_one("subneg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_one("subovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // 8 back-to-back beats, consumer stalls cycles 3..7.
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      in_q.push_back({r[1], r[0], r[31:16], 16'(r[15:0] ^ (i * 16'h1111))});
    end
    run_stream("bp", 3, 8, 60);

    // Reset with 3 beats in flight and a 4th offered during reset.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inA = 16'(16'h1000 * (i + 1)); inB = 16'h0123; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    inA = 16'h4444; rst_n = 1'b0;
    #1;
    chk("mid_rst_ovalid", out_valid, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_irdy", in_ready, 1);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("rst_ghost", seen, 0);
    send_one("post_rst", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);

    // Low-slice sweep, both modes, random upper bits, 1 beat/cycle.
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) begin
          r = $urandom;
          in_q.push_back({1'(m), r[0], r[31:20], 4'(j), r[15:4], 4'(i)});
        end
    run_stream("sweep", -1, -1, 700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_adder_n.md
PIPE_ADDER_N -- requirements
Module: pipe_adder_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal values are multiples of LANE, minimum 4.
REQ-002 SHALL have parameter LANE, default 4, bits added per pipeline stage; STAGES = WIDTH/LANE.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port inA  input  WIDTH  operand A.
REQ-008 SHALL have port inB  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in when sub=0; borrow-in when sub=1.
REQ-010 SHALL have port sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port s  output  WIDTH  sum/difference.
REQ-014 SHALL have port cout  output  1  raw carry out of the MSB.
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Arithmetic SHALL be: sub=0 -> {cout,s} = inA + inB + cin; sub=1 -> {cout,s} = inA + ~inB + ~cin, i.e. s = inA - inB - cin mod 2^WIDTH, and cout=1 means no borrow.
REQ-017 ovf SHALL be 1 iff the MSBs of inA and of the effective B operand are equal and the MSB of s differs from them.
REQ-018 The carry chain SHALL be split into STAGES registers: stage k adds bits [k*LANE +: LANE] using the carry registered by stage k-1; upper operand slices and finished lower result slices travel alongside in pipeline registers.
REQ-019 Each stage SHALL hold a valid bit; a beat is accepted when in_valid && in_ready.
REQ-020 A global advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en (combinational; never depends on in_valid).
REQ-021 When en=1, every stage SHALL shift one position per cycle; stage 0 loads the accepted beat, or a bubble (valid=0) if none is accepted.
REQ-022 When en=0, all stage registers, including data, SHALL hold unchanged; bubbles are not compressed.
REQ-023 Latency SHALL be exactly STAGES cycles from acceptance to out_valid under continuous out_ready=1; throughput 1 beat/cycle.
REQ-024 out_valid, s, cout and ovf SHALL come directly from the last stage registers and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Beat order SHALL be preserved; no beat is dropped or duplicated.
REQ-026 Inputs inA, inB, cin and sub SHALL be sampled only on the accept cycle; changes at other times have no effect.
REQ-027 Wrap-around SHALL be modular: the all-ones+1 case yields s=0, cout=1, with no saturation.
REQ-028 With STAGES=1 (WIDTH=LANE), the block SHALL degenerate to one registered adder with latency 1 and the same handshake.

Reset
REQ-029 While rst_n=0, all stage valid bits SHALL clear asynchronously, so out_valid=0; s, cout and ovf SHALL read 0.
REQ-030 A reset asserted mid-operation SHALL discard every in-flight beat; no beat accepted before reset appears afterward.
REQ-031 in_ready SHALL be 1 during reset per REQ-020, but no beat SHALL be captured while rst_n=0; the first capture occurs on the first rising clk edge after rst_n rises.

Verification (WIDTH=16, LANE=4, STAGES=4)
REQ-032 The bench SHALL cover: add beat A=0x00FF, B=0x0001, cin=0, out_ready=1 -> exactly 4 cycles later s=0x0100, cout=0, ovf=0 (carry crosses stages 1-2).
REQ-033 The bench SHALL cover: add A=0xFFFF, B=0x0000, cin=1 -> s=0x0000, cout=1, ovf=0; and add A=0x7FFF, B=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
REQ-034 The bench SHALL cover: sub A=0x0005, B=0x0007, cin=0 -> s=0xFFFE, cout=0, ovf=0; and sub A=0x8000, B=0x0001, cin=0 -> s=0x7FFF, cout=1, ovf=1.
REQ-035 The bench SHALL cover: 8 back-to-back beats with out_ready held 0 from cycle 3 for 5 cycles -> in_ready=0 once out_valid=1, output held stable, all 8 results emerge in order once out_ready returns to 1.
REQ-036 The bench SHALL cover: rst_n pulsed low for 1 cycle with 3 beats in flight -> out_valid=0 immediately, none of the 3 results ever appears, and a new beat then completes with 4-cycle latency.
REQ-037 The bench SHALL cover: exhaustive sweep of the low 4-bit slices, i,j in 0..15, both modes, random upper bits, streamed at 1 beat/cycle -> every result matches the reference model from REQ-016/017.
